// File: rtl/multdiv_stall_ctrl.sv
// multdiv_stall_ctrl
// Sequences the multi-cycle multiplier/divider beside the execute-stage ALU.
// A mul/div in D/X gets a one-cycle start pulse and the front of the pipe is
// stalled until the unit answers. The result then goes to X/M for one cycle.
// On an exception or timeout the instruction is rewritten to setx carrying
// the rstatus code (4 = mul, 5 = div).
module multdiv_stall_ctrl #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] insn_dx,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        md_valid,
    output logic [31:0] md_out,
    output logic [31:0] md_insn_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    // rstatus code for the setx rewrite: 5 for divide, 4 for multiply
    function automatic logic [26:0] setx_code(input logic is_div_op);
        if (is_div_op) begin
            setx_code = 27'd5;
        end else begin
            setx_code = 27'd4;
        end
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [31:0]       insn_q, insn_d;
    logic [31:0]       out_q, out_d;
    logic [31:0]       insn_out_q, insn_out_d;
    logic              kind_q, kind_d;

    logic              is_mul_s;
    logic              is_div_s;
    logic              is_md_s;
    logic              start_ok_s;

    // Decode of mul/div in D/X and the combinational start/stall outputs
    always_comb begin
        is_mul_s   = (insn_dx[31:27] == 5'b00000) && (insn_dx[6:2] == 5'b00110);
        is_div_s   = (insn_dx[31:27] == 5'b00000) && (insn_dx[6:2] == 5'b00111);
        is_md_s    = is_mul_s | is_div_s;
        // Starts are only accepted from IDLE, so DONE never retriggers on the
        // same instruction still sitting in D/X.
        start_ok_s = (state_q == S_IDLE) && !flush;
        ctrl_MULT  = start_ok_s && is_mul_s;
        ctrl_DIV   = start_ok_s && is_div_s;
        stall      = (state_q == S_BUSY) || (start_ok_s && is_md_s);
        md_valid   = (state_q == S_DONE);
        busy       = (state_q == S_BUSY);
    end

    assign md_opA      = opa_q;
    assign md_opB      = opb_q;
    assign md_out      = out_q;
    assign md_insn_out = insn_out_q;

    // Next-state and datapath register computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        insn_d     = insn_q;
        out_d      = out_q;
        insn_out_d = insn_out_q;
        kind_d     = kind_q;
        case (state_q)
            S_IDLE: begin
                if (is_md_s && !flush) begin
                    state_d = S_BUSY;
                    opa_d   = A;
                    opb_d   = B;
                    insn_d  = insn_dx;
                    kind_d  = is_div_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    // Squashed: drop the operation, a late RDY lands in IDLE
                    state_d = S_IDLE;
                end else if (md_resultRDY) begin
                    state_d = S_DONE;
                    if (md_exception) begin
                        out_d      = {5'b00000, setx_code(kind_q)};
                        insn_out_d = {5'b10101, setx_code(kind_q)};
                    end else begin
                        out_d      = md_result;
                        insn_out_d = insn_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Unit never answered: report it like an exception
                    state_d    = S_DONE;
                    out_d      = {5'b00000, setx_code(kind_q)};
                    insn_out_d = {5'b10101, setx_code(kind_q)};
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            opa_q      <= 32'd0;
            opb_q      <= 32'd0;
            insn_q     <= 32'd0;
            out_q      <= 32'd0;
            insn_out_q <= 32'd0;
            kind_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            insn_q     <= insn_d;
            out_q      <= out_d;
            insn_out_q <= insn_out_d;
            kind_q     <= kind_d;
        end
    end

endmodule

// File: doc/multdiv_stall_ctrl.md
Name: multdiv_stall_ctrl

Overview:
- Sequences the multi-cycle multiplier/divider sitting beside the single-cycle ALU in the execute stage.
- Detects mul/div in the D/X latch and issues a one-cycle start pulse to the multdiv unit.
- Stalls fetch/decode/execute until the unit reports ready, then hands the result and instruction to X/M for one cycle.
- On multdiv exception or timeout, rewrites the instruction to setx with rstatus code (4 = mul, 5 = div), matching the ALU overflow path.

Parameters:
- MAX_CYCLES, 40, BUSY cycles allowed before a forced timeout exception.
- CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- insn_dx  in  32  instruction currently in the D/X latch.
- A  in  32  operand A from the D/X latch (post-bypass).
- B  in  32  operand B from the D/X latch (post-bypass).
- flush  in  1  branch/jump squash of D/X; aborts any operation in flight.
- md_result  in  32  result from the multdiv unit.
- md_exception  in  1  multdiv exception (mul overflow, div by zero); valid only with md_resultRDY.
- md_resultRDY  in  1  multdiv result valid.
- ctrl_MULT  out  1  one-cycle multiply start.
- ctrl_DIV  out  1  one-cycle divide start.
- md_opA  out  32  latched operand A to the multdiv unit.
- md_opB  out  32  latched operand B to the multdiv unit.
- stall  out  1  freezes PC, F/D and D/X.
- md_valid  out  1  result/insn below are valid; X/M selects them over the ALU output.
- md_out  out  32  result, or rstatus code on exception.
- md_insn_out  out  32  original instruction, or rewritten setx on exception.
- busy  out  1  state == BUSY (debug/perf counter).

Behaviour:
- Decode:
  - is_mul = (insn_dx[31:27] == 5'b00000) && (insn_dx[6:2] == 5'b00110).
  - is_div = same opcode test with insn_dx[6:2] == 5'b00111.
  - is_md = is_mul | is_div.
- State machine: IDLE, BUSY, DONE. All registers clear on reset, regardless of state.
- Reset values: state = IDLE, counter = 0, md_opA = 0, md_opB = 0, md_out = 0, md_insn_out = 0, kind = 0. All combinational outputs evaluate to 0 in IDLE with no md instruction present.
- IDLE:
  - If is_md && !flush, assert ctrl_MULT or ctrl_DIV combinationally this cycle, and assert stall.
  - On the same edge: latch A→md_opA, B→md_opB, insn_dx, and kind (mul/div); clear the counter; go to BUSY.
  - Otherwise remain in IDLE with no stall.
- BUSY:
  - stall = 1; counter increments every cycle.
  - flush → IDLE; no md_valid is produced; any later md_resultRDY is ignored.
  - Else if md_resultRDY and !md_exception: md_out ← md_result, md_insn_out ← latched insn; go to DONE.
  - Else if md_resultRDY and md_exception: md_out ← 4 (mul) or 5 (div), md_insn_out ← {5'b10101, 27'd4 or 27'd5}; go to DONE.
  - Else if counter == MAX_CYCLES−1: same rewrite as the exception case; go to DONE.
- DONE:
  - md_valid = 1 and stall = 0 for exactly one cycle, so the instruction advances to X/M carrying md_out.
  - is_md is ignored this cycle, since the same instruction is still visible in D/X and must not retrigger.
  - Unconditionally → IDLE.
- Latency: the start cycle plus N BUSY cycles (N = cycles until RDY), plus 1 DONE cycle. stall is high for 1+N cycles.
- Precedence:
  - flush beats md_resultRDY in the same cycle.
  - reset beats everything.
  - Timeout and RDY in the same cycle: RDY wins.
- ctrl_MULT and ctrl_DIV are never high together, and never high outside IDLE.
- md_opA and md_opB hold stable from the start edge until the next start.
- Back-to-back mul/div (a new md instruction in D/X the cycle after DONE): a new start is issued from IDLE with no extra bubble.

Test Plan:
1. Mul: insn_dx = mul $3,$1,$2 with A=6, B=7; RDY after 32 cycles with md_result=42. Expect ctrl_MULT high 1 cycle, stall high 33 cycles, then md_valid=1 for 1 cycle with md_out=42 and md_insn_out = original insn.
2. Div by zero: div with A=9, B=0; RDY with md_exception=1. Expect md_out=5, md_insn_out=32'hA8000005, ctrl_DIV pulsed exactly once.
3. Flush during BUSY at cycle 10, then RDY at cycle 32. Expect state IDLE after flush, stall low, and no md_valid ever.
4. Timeout: RDY never asserted with a mul in flight. Expect md_valid at BUSY cycle MAX_CYCLES and md_out=4.
5. Back-to-back: mul then div in consecutive D/X slots. Expect two distinct start pulses, no retrigger during DONE, and two md_valid pulses.
6. Reset asserted during BUSY. Expect all outputs 0 and state IDLE on the next edge; a subsequent stray RDY is ignored.
